asrv32_trap_ctrl: RTL and testbench
===================================

# asrv32_trap_ctrl

Machine-mode trap controller for the ASRV32 pipeline. Owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause and mtval. Detects exceptions, enabled interrupts and MRET on the instruction entering writeback, then sequences a one-instruction hold followed by a single trap-entry or trap-return pulse. Drives the writeback stage's `go_to_trap` / `return_from_trap` / trap-address / return-address inputs and serves the CSR unit's read/write port for these registers.

## Interface
- `MTVEC_RESET`, 32'h0000_0000: reset value of mtvec (bits[1:0] = mode).
- `i_clk` in 1: clock.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_ce` in 1: writeback stage clock enable; instruction at `i_pc` is valid.
- `i_pc` in 32: PC of the instruction entering writeback.
- `i_instr_misaligned`, `i_illegal`, `i_ecall`, `i_ebreak`, `i_load_misaligned`, `i_store_misaligned`, `i_mret` in 1 each: decoded event flags for that instruction.
- `i_fault_addr` in 32: faulting address for misaligned events.
- `i_ext_irq`, `i_sw_irq`, `i_timer_irq` in 1 each: level interrupt lines.
- `i_csr_we` in 1, `i_csr_addr` in 12, `i_csr_wdata` in 32: CSR write port, already op-resolved by the CSR unit.
- `o_csr_rdata` out 32: combinational read of `i_csr_addr`; 0 for unowned addresses.
- `o_go_to_trap` out 1, `o_return_from_trap` out 1: to writeback.
- `o_trap_address` out 32, `o_return_address` out 32: to writeback.
- `o_stall` out 1: holds the pipeline in the detection cycle.

## Operation
- States: IDLE, TRAP, RETURN.
- IDLE, with `i_ce` = 1, evaluated in priority order:
  - Exception, in order instr-misaligned(0) > illegal(2) > ebreak(3) > ecall(11) > load-misaligned(4) > store-misaligned(6).
  - Then interrupt, only if MIE = 1 and the matching mie bit is set, in order ext(11) > sw(3) > timer(7).
  - Then `i_mret`.
- Trap detected:
  - `o_stall` = 1 combinationally.
  - At the clock edge: mepc ← `{i_pc[31:2], 2'b00}`; mcause ← `{is_irq, 27'b0, code}`; mtval ← `i_fault_addr` for misaligned events, else 0; MPIE ← MIE; MIE ← 0.
  - Next state TRAP.
- MRET detected:
  - `o_stall` = 1.
  - At the clock edge: MIE ← MPIE, MPIE ← 1.
  - Next state RETURN.
- TRAP:
  - `o_go_to_trap` = 1.
  - `o_trap_address` = mtvec base (`{mtvec[31:2], 2'b00}`). When mtvec mode = 1 and mcause[31] = 1, it is base + 4·code.
  - Stays in TRAP while `i_ce` = 0. Goes to IDLE on the first cycle with `i_ce` = 1.
  - No detection occurs in TRAP.
- RETURN: same as TRAP, but drives `o_return_from_trap` = 1 with `o_return_address` = mepc.
- mip is read-only: `{20'b0, ext, 3'b0, timer, 3'b0, sw, 3'b0}`, i.e. ext = bit 11, timer = bit 7, sw = bit 3. mie uses the same bit positions.
- CSR addresses: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
- Write rules:
  - mepc writes force bits[1:0] = 0.
  - mtvec mode values 2 and 3 are stored as 0.
  - Writes to mip are ignored.
- Same-cycle collision: a trap/MRET update of mstatus/mepc/mcause/mtval overrides a CSR write to the same register in that cycle. Writes to other registers proceed.

## Timing
- Reset (synchronous, `i_rst_n` = 0 at the edge):
  - State IDLE; `o_go_to_trap` = `o_return_from_trap` = `o_stall` = 0.
  - mtvec = `MTVEC_RESET`; mstatus, mie, mepc, mcause, mtval = 0.
  - `o_trap_address` = mtvec base; `o_return_address` = 0.
- Reset while in TRAP or RETURN aborts the pulse on the next edge.
- Latency:
  - Detection in cycle N: stall in N, CSRs updated at the end of N.
  - `o_go_to_trap` / `o_return_from_trap` asserted from N+1 until the first `i_ce` cycle. Back to IDLE after that cycle.
  - Minimum 2 cycles per trap.
- Outputs `o_go_to_trap`, `o_return_from_trap`, `o_trap_address` and `o_return_address` decode from registered state and CSRs only, with no combinational path from the event inputs.
- Only `o_stall` and `o_csr_rdata` are combinational from inputs.
- An exception and an interrupt in the same cycle: the exception wins; the interrupt stays pending.
- An exception and `i_mret` in the same cycle: the exception wins.
- An interrupt asserted while in TRAP/RETURN is taken after IDLE is re-entered, if still enabled.

## Structure
- Add to `asrv32_header.vh`:
  - CSR address constants.
  - mcause code constants.
  - mstatus bit indices.
  - State encodings `TRAP_IDLE`/`TRAP_ENTER`/`TRAP_RETURN`.
- One combinational sub-module, `asrv32_trap_prio`: event flags plus enabled interrupts in, `{valid, is_irq, code[3:0]}` out.

## Test plan
- `i_illegal` = 1, `i_pc` = 0x104, mtvec = 0x200 → stall 1 cycle; mepc = 0x104, mcause = 2, mtval = 0; next cycle `o_go_to_trap` = 1, `o_trap_address` = 0x200; MIE = 0.
- MIE = 1, mie[7] = 1, `i_timer_irq` = 1, mtvec = 0x201 → mcause = 0x8000_0007, `o_trap_address` = 0x21C.
- `i_load_misaligned` with `i_fault_addr` = 0x1003 and `i_ext_irq` enabled, same cycle → mcause = 4, mtval = 0x1003; after return to IDLE, ext interrupt taken with mcause = 0x8000_000B.
- mepc = 0x140, MPIE = 1, `i_mret` → `o_return_from_trap` = 1, `o_return_address` = 0x140, MIE = 1; hold `i_ce` = 0 for 3 cycles → pulse held 3 cycles, clears after the first `i_ce`.
- CSR write mepc = 0x333 in the same cycle as an ecall at `i_pc` = 0x80 → mepc reads 0x80, mcause = 11; separate write mepc = 0x333 → reads 0x330.
- Assert reset while in TRAP → next edge: all pulses 0, mtvec = `MTVEC_RESET`, mstatus = 0.

Source files
------------

// File: rtl/asrv32_trap_ctrl_pkg.sv
// Shared constants and types for the ASRV32 machine-mode trap controller.
package asrv32_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL            = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_SW           = 4'd3;
    localparam logic [3:0] CAUSE_IRQ_TIMER        = 4'd7;
    localparam logic [3:0] CAUSE_IRQ_EXT          = 4'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam int IRQ_SW_BIT    = 3;
    localparam int IRQ_TIMER_BIT = 7;
    localparam int IRQ_EXT_BIT   = 11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    typedef enum logic [1:0] {
        TRAP_IDLE   = 2'd0,
        TRAP_ENTER  = 2'd1,
        TRAP_RETURN = 2'd2
    } trap_state_t;

    // Only direct (0) and vectored (1) modes exist; reserved modes fall back to direct.
    function automatic logic [31:0] legalize_mtvec(input logic [31:0] value);
        logic [31:0] result;
        result = value & 32'hFFFF_FFFC;
        if (value[1:0] == 2'b01) begin
            result[0] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/asrv32_trap_prio.sv
// Fixed-priority encoder picking the winning trap cause for the writeback instruction.
module asrv32_trap_prio
    import asrv32_trap_ctrl_pkg::*;
(
    input  logic       instr_misaligned,
    input  logic       illegal,
    input  logic       ebreak,
    input  logic       ecall,
    input  logic       load_misaligned,
    input  logic       store_misaligned,
    input  logic       irq_ext_en,
    input  logic       irq_sw_en,
    input  logic       irq_timer_en,
    output logic       valid,
    output logic       is_irq,
    output logic [3:0] code
);

    // Exceptions always beat interrupts; within each group the order is fixed.
    always_comb begin
        valid  = 1'b1;
        is_irq = 1'b0;
        code   = 4'd0;
        if (instr_misaligned) begin
            code = CAUSE_INSTR_MISALIGNED;
        end else if (illegal) begin
            code = CAUSE_ILLEGAL;
        end else if (ebreak) begin
            code = CAUSE_EBREAK;
        end else if (ecall) begin
            code = CAUSE_ECALL;
        end else if (load_misaligned) begin
            code = CAUSE_LOAD_MISALIGNED;
        end else if (store_misaligned) begin
            code = CAUSE_STORE_MISALIGNED;
        end else if (irq_ext_en) begin
            is_irq = 1'b1;
            code   = CAUSE_IRQ_EXT;
        end else if (irq_sw_en) begin
            is_irq = 1'b1;
            code   = CAUSE_IRQ_SW;
        end else if (irq_timer_en) begin
            is_irq = 1'b1;
            code   = CAUSE_IRQ_TIMER;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/asrv32_trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs and sequences trap entry / MRET pulses.
module asrv32_trap_ctrl
    import asrv32_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic [31:0] i_pc,
    input  logic        i_instr_misaligned,
    input  logic        i_illegal,
    input  logic        i_ecall,
    input  logic        i_ebreak,
    input  logic        i_load_misaligned,
    input  logic        i_store_misaligned,
    input  logic        i_mret,
    input  logic [31:0] i_fault_addr,
    input  logic        i_ext_irq,
    input  logic        i_sw_irq,
    input  logic        i_timer_irq,
    input  logic        i_csr_we,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_go_to_trap,
    output logic        o_return_from_trap,
    output logic [31:0] o_trap_address,
    output logic [31:0] o_return_address,
    output logic        o_stall
);

    trap_state_t state;
    trap_state_t state_next;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;

    logic [31:0] mip_value;
    logic [31:0] mstatus_value;
    logic [31:0] mtvec_base;

    logic        prio_valid;
    logic        prio_is_irq;
    logic [3:0]  prio_code;
    logic        detect_trap;
    logic        detect_mret;
    logic        fault_is_addr;

    assign mip_value = {20'b0, i_ext_irq, 3'b0, i_timer_irq, 3'b0, i_sw_irq, 3'b0};
    assign mstatus_value = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mtvec_base = mtvec_reg & 32'hFFFF_FFFC;

    asrv32_trap_prio u_prio (
        .instr_misaligned (i_instr_misaligned),
        .illegal          (i_illegal),
        .ebreak           (i_ebreak),
        .ecall            (i_ecall),
        .load_misaligned  (i_load_misaligned),
        .store_misaligned (i_store_misaligned),
        .irq_ext_en       (mstatus_mie & mie_reg[IRQ_EXT_BIT]   & i_ext_irq),
        .irq_sw_en        (mstatus_mie & mie_reg[IRQ_SW_BIT]    & i_sw_irq),
        .irq_timer_en     (mstatus_mie & mie_reg[IRQ_TIMER_BIT] & i_timer_irq),
        .valid            (prio_valid),
        .is_irq           (prio_is_irq),
        .code             (prio_code)
    );

    assign detect_trap = (state == TRAP_IDLE) && i_ce && prio_valid;
    assign detect_mret = (state == TRAP_IDLE) && i_ce && !prio_valid && i_mret;
    assign fault_is_addr = !prio_is_irq &&
                           ((prio_code == CAUSE_INSTR_MISALIGNED) ||
                            (prio_code == CAUSE_LOAD_MISALIGNED)  ||
                            (prio_code == CAUSE_STORE_MISALIGNED));

    // Next-state and stall decode; pulses end on the first enabled writeback cycle.
    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        case (state)
            TRAP_IDLE: begin
                if (detect_trap) begin
                    o_stall    = 1'b1;
                    state_next = TRAP_ENTER;
                end else if (detect_mret) begin
                    o_stall    = 1'b1;
                    state_next = TRAP_RETURN;
                end
            end
            TRAP_ENTER, TRAP_RETURN: begin
                if (i_ce) begin
                    state_next = TRAP_IDLE;
                end
            end
            default: state_next = TRAP_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= TRAP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CSR storage: software writes first, then trap/MRET updates so they win a collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= 32'b0;
            mtvec_reg    <= legalize_mtvec(MTVEC_RESET);
            mepc_reg     <= 32'b0;
            mcause_reg   <= 32'b0;
            mtval_reg    <= 32'b0;
        end else begin
            if (i_csr_we) begin
                case (i_csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= i_csr_wdata[MSTATUS_MIE_BIT];
                        mstatus_mpie <= i_csr_wdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:    mie_reg    <= i_csr_wdata & MIE_MASK;
                    CSR_MTVEC:  mtvec_reg  <= legalize_mtvec(i_csr_wdata);
                    CSR_MEPC:   mepc_reg   <= i_csr_wdata & 32'hFFFF_FFFC;
                    CSR_MCAUSE: mcause_reg <= i_csr_wdata;
                    CSR_MTVAL:  mtval_reg  <= i_csr_wdata;
                    default: ;
                endcase
            end
            if (detect_trap) begin
                mepc_reg     <= i_pc & 32'hFFFF_FFFC;
                mcause_reg   <= {prio_is_irq, 27'b0, prio_code};
                mtval_reg    <= fault_is_addr ? i_fault_addr : 32'b0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (detect_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    // CSR read mux; addresses this block does not own read as zero.
    always_comb begin
        o_csr_rdata = 32'b0;
        case (i_csr_addr)
            CSR_MSTATUS: o_csr_rdata = mstatus_value;
            CSR_MIE:     o_csr_rdata = mie_reg;
            CSR_MTVEC:   o_csr_rdata = mtvec_reg;
            CSR_MEPC:    o_csr_rdata = mepc_reg;
            CSR_MCAUSE:  o_csr_rdata = mcause_reg;
            CSR_MTVAL:   o_csr_rdata = mtval_reg;
            CSR_MIP:     o_csr_rdata = mip_value;
            default:     o_csr_rdata = 32'b0;
        endcase
    end

    // Writeback-facing outputs decode only from registered state and CSRs.
    always_comb begin
        o_go_to_trap       = (state == TRAP_ENTER);
        o_return_from_trap = (state == TRAP_RETURN);
        o_return_address   = mepc_reg;
        o_trap_address     = mtvec_base;
        if (mtvec_reg[0] && mcause_reg[31]) begin
            o_trap_address = mtvec_base + {mcause_reg[29:0], 2'b00};
        end
    end

endmodule

// File: tb/tb_asrv32_trap_ctrl.sv
// Directed self-checking bench for asrv32_trap_ctrl.
module tb_asrv32_trap_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ce;
    logic [31:0] i_pc;
    logic        i_instr_misaligned;
    logic        i_illegal;
    logic        i_ecall;
    logic        i_ebreak;
    logic        i_load_misaligned;
    logic        i_store_misaligned;
    logic        i_mret;
    logic [31:0] i_fault_addr;
    logic        i_ext_irq;
    logic        i_sw_irq;
    logic        i_timer_irq;
    logic        i_csr_we;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic [31:0] o_csr_rdata;
    logic        o_go_to_trap;
    logic        o_return_from_trap;
    logic [31:0] o_trap_address;
    logic [31:0] o_return_address;
    logic        o_stall;

    int errors;
    int checks;

    asrv32_trap_ctrl #(.MTVEC_RESET(32'h0000_0000)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_ce               (i_ce),
        .i_pc               (i_pc),
        .i_instr_misaligned (i_instr_misaligned),
        .i_illegal          (i_illegal),
        .i_ecall            (i_ecall),
        .i_ebreak           (i_ebreak),
        .i_load_misaligned  (i_load_misaligned),
        .i_store_misaligned (i_store_misaligned),
        .i_mret             (i_mret),
        .i_fault_addr       (i_fault_addr),
        .i_ext_irq          (i_ext_irq),
        .i_sw_irq           (i_sw_irq),
        .i_timer_irq        (i_timer_irq),
        .i_csr_we           (i_csr_we),
        .i_csr_addr         (i_csr_addr),
        .i_csr_wdata        (i_csr_wdata),
        .o_csr_rdata        (o_csr_rdata),
        .o_go_to_trap       (o_go_to_trap),
        .o_return_from_trap (o_return_from_trap),
        .o_trap_address     (o_trap_address),
        .o_return_address   (o_return_address),
        .o_stall            (o_stall)
    );

    // Free-running clock, 100 time units per cycle.
    initial begin
        i_clk = 1'b0;
        forever #50 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        i_csr_addr = addr;
        #1;
        checkOutput(tag, o_csr_rdata, expected);
    endtask

    // ev = {instr_misaligned, illegal, ebreak, ecall, load_misaligned, store_misaligned, mret}
    task automatic applyStimulus(input logic ce, input logic [6:0] ev, input logic [31:0] pc, input logic [31:0] fault);
        i_ce               = ce;
        i_instr_misaligned = ev[6];
        i_illegal          = ev[5];
        i_ebreak           = ev[4];
        i_ecall            = ev[3];
        i_load_misaligned  = ev[2];
        i_store_misaligned = ev[1];
        i_mret             = ev[0];
        i_pc               = pc;
        i_fault_addr       = fault;
        #1;
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
        i_csr_we    = 1'b1;
        i_csr_addr  = addr;
        i_csr_wdata = data;
        tick();
        i_csr_we    = 1'b0;
    endtask

    task automatic leaveTrap();
        i_ce = 1'b1;
        tick();
        i_ce = 1'b0;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        i_rst_n = 1'b0;
        i_ext_irq = 1'b0;
        i_sw_irq = 1'b0;
        i_timer_irq = 1'b0;
        i_csr_we = 1'b0;
        i_csr_addr = 12'h000;
        i_csr_wdata = 32'h0;
        applyStimulus(1'b0, 7'b0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_go", {31'b0, o_go_to_trap}, 32'h0);
        checkOutput("rst_ret", {31'b0, o_return_from_trap}, 32'h0);
        checkOutput("rst_stall", {31'b0, o_stall}, 32'h0);
        checkOutput("rst_trap_addr", o_trap_address, 32'h0);
        checkOutput("rst_ret_addr", o_return_address, 32'h0);
        readCheck("rst_mtvec", 12'h305, 32'h0);
        readCheck("rst_mstatus", 12'h300, 32'h0);
        readCheck("rst_mcause", 12'h342, 32'h0);
        i_rst_n = 1'b1;
        tick();

        // Illegal instruction, direct mode
        csrWrite(12'h305, 32'h0000_0200);
        applyStimulus(1'b1, 7'b0100000, 32'h0000_0104, 32'h0);
        checkOutput("ill_stall", {31'b0, o_stall}, 32'h1);
        checkOutput("ill_go_early", {31'b0, o_go_to_trap}, 32'h0);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0104, 32'h0);
        checkOutput("ill_go", {31'b0, o_go_to_trap}, 32'h1);
        checkOutput("ill_stall_off", {31'b0, o_stall}, 32'h0);
        checkOutput("ill_trap_addr", o_trap_address, 32'h0000_0200);
        readCheck("ill_mepc", 12'h341, 32'h0000_0104);
        readCheck("ill_mcause", 12'h342, 32'h0000_0002);
        readCheck("ill_mtval", 12'h343, 32'h0);
        readCheck("ill_mstatus", 12'h300, 32'h0);
        leaveTrap();
        checkOutput("ill_go_clear", {31'b0, o_go_to_trap}, 32'h0);

        // Timer interrupt, vectored mode
        csrWrite(12'h305, 32'h0000_0201);
        csrWrite(12'h304, 32'h0000_0080);
        csrWrite(12'h300, 32'h0000_0008);
        readCheck("tmr_mtvec", 12'h305, 32'h0000_0201);
        readCheck("tmr_mstatus_pre", 12'h300, 32'h0000_0008);
        i_timer_irq = 1'b1;
        applyStimulus(1'b1, 7'b0, 32'h0000_02A6, 32'h0);
        checkOutput("tmr_stall", {31'b0, o_stall}, 32'h1);
        tick();
        i_timer_irq = 1'b0;
        applyStimulus(1'b0, 7'b0, 32'h0000_02A6, 32'h0);
        readCheck("tmr_mcause", 12'h342, 32'h8000_0007);
        checkOutput("tmr_trap_addr", o_trap_address, 32'h0000_021C);
        readCheck("tmr_mepc", 12'h341, 32'h0000_02A4);
        readCheck("tmr_mstatus", 12'h300, 32'h0000_0080);
        leaveTrap();
        i_timer_irq = 1'b1;
        applyStimulus(1'b1, 7'b0, 32'h0000_02A8, 32'h0);
        checkOutput("tmr_masked_stall", {31'b0, o_stall}, 32'h0);
        i_timer_irq = 1'b0;
        applyStimulus(1'b0, 7'b0, 32'h0000_02A8, 32'h0);

        // Load misaligned beats a pending external interrupt
        csrWrite(12'h304, 32'h0000_0880);
        csrWrite(12'h300, 32'h0000_0008);
        readCheck("mie_rd", 12'h304, 32'h0000_0880);
        i_ext_irq = 1'b1;
        applyStimulus(1'b1, 7'b0000100, 32'h0000_0300, 32'h0000_1003);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0300, 32'h0000_1003);
        readCheck("ld_mcause", 12'h342, 32'h0000_0004);
        readCheck("ld_mtval", 12'h343, 32'h0000_1003);
        checkOutput("ld_trap_addr", o_trap_address, 32'h0000_0200);
        checkOutput("ld_go", {31'b0, o_go_to_trap}, 32'h1);
        csrWrite(12'h300, 32'h0000_0008);
        i_ce = 1'b1;
        tick();
        checkOutput("ext_stall", {31'b0, o_stall}, 32'h1);
        tick();
        i_ext_irq = 1'b0;
        i_ce = 1'b0;
        #1;
        readCheck("ext_mcause", 12'h342, 32'h8000_000B);
        readCheck("ext_mtval", 12'h343, 32'h0);
        checkOutput("ext_trap_addr", o_trap_address, 32'h0000_022C);
        leaveTrap();

        // MRET with the writeback stage held off for three cycles
        csrWrite(12'h341, 32'h0000_0140);
        csrWrite(12'h300, 32'h0000_0080);
        applyStimulus(1'b1, 7'b0000001, 32'h0000_0400, 32'h0);
        checkOutput("mret_stall", {31'b0, o_stall}, 32'h1);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0400, 32'h0);
        checkOutput("mret_ret_c1", {31'b0, o_return_from_trap}, 32'h1);
        checkOutput("mret_go", {31'b0, o_go_to_trap}, 32'h0);
        checkOutput("mret_ret_addr", o_return_address, 32'h0000_0140);
        readCheck("mret_mstatus", 12'h300, 32'h0000_0088);
        tick();
        checkOutput("mret_ret_c2", {31'b0, o_return_from_trap}, 32'h1);
        tick();
        checkOutput("mret_ret_c3", {31'b0, o_return_from_trap}, 32'h1);
        i_ce = 1'b1;
        #1;
        checkOutput("mret_ret_ce", {31'b0, o_return_from_trap}, 32'h1);
        tick();
        checkOutput("mret_ret_clear", {31'b0, o_return_from_trap}, 32'h0);
        i_ce = 1'b0;

        // Ecall with mret and a colliding mepc write in the same cycle
        i_csr_we = 1'b1;
        i_csr_addr = 12'h341;
        i_csr_wdata = 32'h0000_0333;
        applyStimulus(1'b1, 7'b0001001, 32'h0000_0080, 32'h0);
        tick();
        i_csr_we = 1'b0;
        applyStimulus(1'b0, 7'b0, 32'h0000_0080, 32'h0);
        checkOutput("ecall_go", {31'b0, o_go_to_trap}, 32'h1);
        checkOutput("ecall_ret", {31'b0, o_return_from_trap}, 32'h0);
        readCheck("ecall_mepc", 12'h341, 32'h0000_0080);
        readCheck("ecall_mcause", 12'h342, 32'h0000_000B);
        readCheck("ecall_mstatus", 12'h300, 32'h0000_0080);
        leaveTrap();
        csrWrite(12'h341, 32'h0000_0333);
        readCheck("mepc_align", 12'h341, 32'h0000_0330);

        // Exception ordering
        applyStimulus(1'b1, 7'b1000010, 32'h0000_0500, 32'h0000_0055);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0500, 32'h0);
        readCheck("imis_mcause", 12'h342, 32'h0000_0000);
        readCheck("imis_mtval", 12'h343, 32'h0000_0055);
        leaveTrap();
        applyStimulus(1'b1, 7'b0011000, 32'h0000_0504, 32'h0000_0077);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0504, 32'h0);
        readCheck("ebrk_mcause", 12'h342, 32'h0000_0003);
        readCheck("ebrk_mtval", 12'h343, 32'h0);
        leaveTrap();

        // CSR write rules
        csrWrite(12'h305, 32'h0000_0203);
        readCheck("mtvec_mode3", 12'h305, 32'h0000_0200);
        csrWrite(12'h344, 32'hFFFF_FFFF);
        readCheck("mip_ignored", 12'h344, 32'h0);
        i_sw_irq = 1'b1;
        i_timer_irq = 1'b1;
        readCheck("mip_lines", 12'h344, 32'h0000_0088);
        i_sw_irq = 1'b0;
        i_timer_irq = 1'b0;
        readCheck("unowned", 12'h123, 32'h0);

        // Reset while in TRAP
        csrWrite(12'h300, 32'h0000_0088);
        applyStimulus(1'b1, 7'b0100000, 32'h0000_0600, 32'h0);
        tick();
        applyStimulus(1'b0, 7'b0, 32'h0000_0600, 32'h0);
        checkOutput("pre_rst_go", {31'b0, o_go_to_trap}, 32'h1);
        i_rst_n = 1'b0;
        tick();
        checkOutput("trst_go", {31'b0, o_go_to_trap}, 32'h0);
        checkOutput("trst_ret", {31'b0, o_return_from_trap}, 32'h0);
        checkOutput("trst_trap_addr", o_trap_address, 32'h0);
        checkOutput("trst_ret_addr", o_return_address, 32'h0);
        readCheck("trst_mtvec", 12'h305, 32'h0);
        readCheck("trst_mstatus", 12'h300, 32'h0);
        readCheck("trst_mepc", 12'h341, 32'h0);
        i_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
